sqrt_job_sequencer: RTL and testbench
=====================================

# sqrt_job_sequencer

Operand sequencer and result collector wrapped around the 16-bit square-root core (`Top`). It buffers incoming 16-bit operands in a small FIFO and issues them to the core one at a time, restarting the core through its active-low reset. It waits for the core's `ready_o`, captures the 8-bit root and the per-operation cycle count, and presents each result on a valid/ready output port. It lets a producer stream operands without tracking core latency.

## Interface

**Parameters**
- `DEPTH`, default 4: operand FIFO entries. Power of two, ≥2.
- `TIMEOUT`, default 300: maximum RUN cycles before a job is aborted. Range 1..2047.

**Ports**
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1: operand valid.
- `in_ready_o` out 1: FIFO not full.
- `in_valor_i` in 16: operand.
- `sq_valor_o` out 16: registered operand to core `valor_i`.
- `sq_rst_n_o` out 1: registered core reset/start, to core `rst_n`.
- `sq_ready_i` in 1: core `ready_o`.
- `sq_root_i` in 8: core `root_o`.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: result accepted.
- `out_valor_o` out 16: operand the result belongs to.
- `out_root_o` out 8: root; 0 on timeout.
- `out_cycles_o` out 11: RUN cycles consumed, saturating at 2047.
- `out_timeout_o` out 1: job aborted by timeout.
- `busy_o` out 1: FSM not IDLE, or FIFO not empty.

## Operation

**FIFO**
- Push when `in_valid_i && in_ready_o`.
- `in_ready_o = !full`, derived from registered pointers. A pop in the same cycle does not allow a push while full.
- Pop only on the IDLE→START transition.

**FSM states: IDLE, START, RUN, HOLD**

IDLE:
- `sq_rst_n_o=0`; core is held in reset.
- If FIFO not empty: pop, load `sq_valor_o`, go to START.

START (exactly one cycle):
- `sq_rst_n_o=0`; cycle counter cleared.
- Go to RUN.

RUN:
- `sq_rst_n_o=1`.
- Each edge: if `sq_ready_i=1`, capture `out_root_o=sq_root_i`, `out_cycles_o=cnt+1`, `out_valor_o=sq_valor_o`, `out_timeout_o=0`, and go to HOLD.
- Else if `cnt+1==TIMEOUT`: `out_root_o=0`, `out_cycles_o=TIMEOUT`, `out_timeout_o=1`, go to HOLD.
- Else `cnt` increments; it saturates at 2047.

HOLD:
- `sq_rst_n_o=1`; core keeps its result.
- `out_valid_o=1`; output fields stable.
- On `out_ready_i=1`, go to IDLE. There is always one IDLE bubble between jobs.

**Other rules**
- `out_*` fields change only on RUN→HOLD. They hold their last value in IDLE.
- Core's `ready_o` is cleared by the START reset cycle, so a stale ready from the previous job is never sampled.

**Reset values (asynchronous, immediate)**
- FIFO empty; FSM IDLE.
- `in_ready_o=1`, `sq_rst_n_o=0`, `sq_valor_o=0`.
- `out_valid_o=0`, `out_root_o=0`, `out_valor_o=0`, `out_cycles_o=0`, `out_timeout_o=0`, `busy_o=0`.
- Reset mid-operation discards the FIFO contents and the in-flight job. No result is emitted.

## Timing

Edge-by-edge for a single job:
- Push at edge E.
- E+1: IDLE→START; `sq_valor_o` valid and `sq_rst_n_o=0` after E+1.
- E+2: START→RUN; `sq_rst_n_o=1`.
- First edge R with `sq_ready_i=1` while in RUN: RUN→HOLD; `out_valid_o=1` after R.
- `out_cycles_o` = number of RUN edges up to and including R.

Other timing rules:
- Accept at edge H → IDLE after H. Next job reaches START at H+1 if the FIFO is non-empty.
- Simultaneous push into an empty FIFO and IDLE check: the pushed entry is not visible until the next edge, so there is no same-edge pop.
- `out_valid_o` never drops without `out_ready_i`.

## Test plan

1. **Single job, real core.** Push 65535, `out_ready_i=1`.
   - Required: `out_root_o=255`, `out_valor_o=65535`, `out_timeout_o=0`, `out_cycles_o` equal to the core's measured latency.
2. **Vector stream.** Push 0, 1, 24, 25, 65535 back-to-back.
   - Required: roots 0, 1, 4, 5, 255, in order, each tagged with its operand.
   - `in_ready_o` drops after 4 outstanding pushes with DEPTH=4.
3. **Output back-pressure.** Hold `out_ready_i=0` for 10 cycles after a result.
   - Required: `out_valid_o` and all fields stay stable.
   - `sq_rst_n_o` stays 1 and no new START occurs until acceptance.
4. **Timeout.** Core model with `sq_ready_i` tied 0, TIMEOUT=8.
   - Required: HOLD with `out_timeout_o=1`, `out_root_o=0`, `out_cycles_o=8`, exactly 8 RUN cycles after START.
5. **Reset mid-RUN.** Push 3 operands, assert `rst_n=0` during the first RUN.
   - Required: all outputs at reset values immediately; `busy_o=0`; no result ever emitted for those operands.
6. **Stale ready.** Core model that holds `sq_ready_i=1` until reset.
   - Required: the second job's result is captured only after its own START cycle; `out_cycles_o≥1` and correct root.

Source files
------------

// File: rtl/sqrt_job_sequencer.sv
// -----------------------------------------------------------------------------
// sqrt_job_sequencer
//
// Buffers 16-bit operands in a small FIFO and runs them through the 16-bit
// square-root core one job at a time. Each job restarts the core through its
// active-low reset. The sequencer then waits for the core's ready and returns
// the root, the operand and the RUN cycle count on a valid/ready result port.
// A job that runs for TIMEOUT cycles without a ready is aborted. It is
// reported with root 0 and the timeout flag set.
//
// State table
//   state | meaning
//   IDLE  | core held in reset; pop next operand when the FIFO has one
//   START | one reset cycle for the core; cycle counter cleared
//   RUN   | core released; wait for ready or timeout
//   HOLD  | result presented on out_*; wait for out_ready_i
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid_i      operand valid          in_ready_o    FIFO not full
//   in_valor_i      operand
//   sq_valor_o      operand to core        sq_rst_n_o    core reset/start
//   sq_ready_i      core done              sq_root_i     core root
//   out_valid_o     result valid           out_ready_i   result accepted
//   out_valor_o     operand of the result  out_root_o    root (0 on timeout)
//   out_cycles_o    RUN cycles used        out_timeout_o job aborted
//   busy_o          FSM active or FIFO not empty
// -----------------------------------------------------------------------------
module sqrt_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] in_valor_i,
  output logic [15:0] sq_valor_o,
  output logic        sq_rst_n_o,
  input  logic        sq_ready_i,
  input  logic [7:0]  sq_root_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] out_valor_o,
  output logic [7:0]  out_root_o,
  output logic [10:0] out_cycles_o,
  output logic        out_timeout_o,
  output logic        busy_o
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [10:0] TIMEOUT_C = 11'(TIMEOUT);
  localparam logic [10:0] CNT_MAX   = 11'h7FF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // FIFO: pointers carry one extra wrap bit to separate full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] mem_q [DEPTH];
  logic        fifo_empty, fifo_full, push, pop;

  logic [10:0] cnt_q, cnt_d, cnt_inc;
  logic        run_last, capture, cnt_clr;

  logic [15:0] sq_valor_q, sq_valor_d;
  logic        sq_rst_n_q, sq_rst_n_d;
  logic [15:0] out_valor_q, out_valor_d;
  logic [7:0]  out_root_q, out_root_d;
  logic [10:0] out_cycles_q, out_cycles_d;
  logic        out_timeout_q, out_timeout_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready_o = !fifo_full;
  assign push       = in_valid_i && !fifo_full;

  assign cnt_inc  = cnt_q + 11'd1;
  assign run_last = (cnt_inc == TIMEOUT_C);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN:   if (sq_ready_i || run_last) state_d = S_HOLD;
      S_HOLD:  if (out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs and strobes
  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    cnt_clr     = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = !fifo_empty;
    case (state_q)
      S_IDLE:  pop = !fifo_empty;
      S_START: begin
        cnt_clr = 1'b1;
        busy_o  = 1'b1;
      end
      S_RUN: begin
        capture = sq_ready_i || run_last;
        busy_o  = 1'b1;
      end
      S_HOLD: begin
        out_valid_o = 1'b1;
        busy_o      = 1'b1;
      end
      default: ;
    endcase
  end

  // FIFO pointers
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read behind the write pointer.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_valor_i;
  end

  // Datapath next values
  always_comb begin
    sq_valor_d    = sq_valor_q;
    cnt_d         = cnt_q;
    out_valor_d   = out_valor_q;
    out_root_d    = out_root_q;
    out_cycles_d  = out_cycles_q;
    out_timeout_d = out_timeout_q;
    // Core runs only in RUN and HOLD; HOLD keeps it out of reset so its result stays put.
    sq_rst_n_d    = (state_d == S_RUN) || (state_d == S_HOLD);

    if (pop) sq_valor_d = mem_q[rd_ptr_q[AW-1:0]];

    if (cnt_clr) begin
      cnt_d = '0;
    end else if ((state_q == S_RUN) && !capture && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_inc;
    end

    if (capture) begin
      out_valor_d = sq_valor_q;
      if (sq_ready_i) begin
        out_root_d    = sq_root_i;
        out_cycles_d  = cnt_inc;
        out_timeout_d = 1'b0;
      end else begin
        out_root_d    = '0;
        out_cycles_d  = TIMEOUT_C;
        out_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_valor_q    <= '0;
      sq_rst_n_q    <= 1'b0;
      cnt_q         <= '0;
      out_valor_q   <= '0;
      out_root_q    <= '0;
      out_cycles_q  <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      sq_valor_q    <= sq_valor_d;
      sq_rst_n_q    <= sq_rst_n_d;
      cnt_q         <= cnt_d;
      out_valor_q   <= out_valor_d;
      out_root_q    <= out_root_d;
      out_cycles_q  <= out_cycles_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign sq_valor_o    = sq_valor_q;
  assign sq_rst_n_o    = sq_rst_n_q;
  assign out_valor_o   = out_valor_q;
  assign out_root_o    = out_root_q;
  assign out_cycles_o  = out_cycles_q;
  assign out_timeout_o = out_timeout_q;

endmodule

// File: tb/tb_sqrt_job_sequencer.sv
module tb_sqrt_job_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_valor;
  logic [15:0] sq_valor;
  logic        sq_rst_n;
  logic        sq_ready;
  logic [7:0]  sq_root;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_valor;
  logic [7:0]  out_root;
  logic [10:0] out_cycles;
  logic        out_timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sqrt_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_valor_i    (in_valor),
    .sq_valor_o    (sq_valor),
    .sq_rst_n_o    (sq_rst_n),
    .sq_ready_i    (sq_ready),
    .sq_root_i     (sq_root),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_valor_o   (out_valor),
    .out_root_o    (out_root),
    .out_cycles_o  (out_cycles),
    .out_timeout_o (out_timeout),
    .busy_o        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int isqrt(int v);
    int r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Core latency in edges after its reset is released, derived from the operand.
  function automatic int lat_of(int v);
    if (v % 17 == 16) return 10;
    return (v % 7) + 1;
  endfunction

  // Behavioural core: counts edges out of reset, raises ready after its
  // latency and keeps it high until reset again.
  logic never_ready = 1'b0;
  int   core_cnt    = 0;
  always @(posedge clk) begin
    if (!sq_rst_n) core_cnt <= 0;
    else           core_cnt <= core_cnt + 1;
  end
  assign sq_ready = sq_rst_n && !never_ready && (core_cnt >= lat_of(int'(sq_valor)) - 1);
  assign sq_root  = sq_ready ? 8'(isqrt(int'(sq_valor))) : 8'hA5;

  typedef struct {
    logic [15:0] valor;
    logic [7:0]  root;
    logic [10:0] cycles;
    logic        to;
  } res_t;

  res_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Back-pressure tracking
  logic        stalled = 1'b0;
  logic [15:0] st_valor;
  logic [7:0]  st_root;
  logic [10:0] st_cycles;
  logic        st_to;
  int          n_results = 0;

  task automatic monitor();
    res_t e;
    int   l;
    if (in_valid && in_ready) begin
      l       = lat_of(int'(in_valor));
      e.valor = in_valor;
      if (never_ready || l > TIMEOUT) begin
        e.root = 8'd0; e.cycles = 11'(TIMEOUT); e.to = 1'b1;
      end else begin
        e.root = 8'(isqrt(int'(in_valor))); e.cycles = 11'(l); e.to = 1'b0;
      end
      exp_q.push_back(e);
    end
    if (stalled) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_valor", 32'(out_valor), 32'(st_valor));
      chk("hold_root", 32'(out_root), 32'(st_root));
      chk("hold_cycles", 32'(out_cycles), 32'(st_cycles));
      chk("hold_to", 32'(out_timeout), 32'(st_to));
    end
    if (out_valid) begin
      chk("hold_core_run", 32'(sq_rst_n), 32'd1);
      if (out_ready) begin
        stalled = 1'b0;
        n_results++;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("res_valor", 32'(out_valor), 32'(e.valor));
          chk("res_root", 32'(out_root), 32'(e.root));
          chk("res_cycles", 32'(out_cycles), 32'(e.cycles));
          chk("res_timeout", 32'(out_timeout), 32'(e.to));
        end
      end else begin
        stalled   = 1'b1;
        st_valor  = out_valor;
        st_root   = out_root;
        st_cycles = out_cycles;
        st_to     = out_timeout;
      end
    end else begin
      stalled = 1'b0;
    end
  endtask

  task automatic cycle(input logic v, input logic [15:0] d, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    in_valor  = d;
    out_ready = ordy;
    #1;
    monitor();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      cycle(1'b0, 16'd0, 1'b1);
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_sq_rst_n"}, 32'(sq_rst_n), 32'd0);
    chk({tag, "_sq_valor"}, 32'(sq_valor), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_root"}, 32'(out_root), 32'd0);
    chk({tag, "_out_valor"}, 32'(out_valor), 32'd0);
    chk({tag, "_out_cycles"}, 32'(out_cycles), 32'd0);
    chk({tag, "_out_to"}, 32'(out_timeout), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  logic [15:0] vec [5];
  int          k;
  int          run_edges;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valor  = '0;
    out_ready = 1'b0;
    #2;
    check_reset_values("rst");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Single job
    cycle(1'b1, 16'hFFFF, 1'b1);
    drain(100);
    chk("single_out_root", 32'(out_root), 32'd255);
    chk("single_n_results", 32'(n_results), 32'd1);

    // Vector stream with output blocked: FIFO fills behind the first job
    vec[0] = 16'd0; vec[1] = 16'd1; vec[2] = 16'd24; vec[3] = 16'd25; vec[4] = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, vec[i], 1'b0);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    cycle(1'b0, 16'd0, 1'b0);
    chk("stream_full", 32'(in_ready), 32'd0);
    chk("stream_busy", 32'(busy), 32'd1);
    // Back-pressure: keep the first result waiting at least 10 cycles
    k = 0;
    while (!out_valid && k < 50) begin
      cycle(1'b0, 16'd0, 1'b0);
      k++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 16'd0, 1'b0);
    chk("bp_in_ready_still_full", 32'(in_ready), 32'd0);
    drain(200);
    chk("stream_n_results", 32'(n_results), 32'd6);

    // Timeout: core never answers
    never_ready = 1'b1;
    cycle(1'b1, 16'd100, 1'b0);
    run_edges = 0;
    k = 0;
    while (!out_valid && k < 50) begin
      cycle(1'b0, 16'd0, 1'b0);
      if (sq_rst_n && !out_valid) run_edges++;
      k++;
    end
    chk("to_run_edges", 32'(run_edges), 32'(TIMEOUT));
    chk("to_out_timeout", 32'(out_timeout), 32'd1);
    chk("to_out_cycles", 32'(out_cycles), 32'(TIMEOUT));
    drain(100);
    never_ready = 1'b0;

    // Back-to-back latency-1 jobs: stale ready must not shortcut the second one
    cycle(1'b1, 16'd7, 1'b1);
    cycle(1'b1, 16'd14, 1'b1);
    drain(100);
    chk("stale_last_cycles", 32'(out_cycles), 32'd1);
    chk("stale_last_root", 32'(out_root), 32'd3);

    // Randomized stream
    for (int i = 0; i < 400; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0:       d = 16'($urandom_range(0, 40));
        1:       d = 16'hFFFF - 16'($urandom_range(0, 3));
        default: d = 16'($urandom);
      endcase
      cycle(1'($urandom_range(0, 1)), d, ($urandom_range(0, 2) != 0));
    end
    drain(500);

    // Reset during the first RUN
    cycle(1'b1, 16'd1000, 1'b1);
    cycle(1'b1, 16'd2000, 1'b1);
    cycle(1'b1, 16'd3000, 1'b1);
    k = 0;
    while (!sq_rst_n && k < 20) begin
      cycle(1'b0, 16'd0, 1'b1);
      k++;
    end
    chk("mid_run_reached", 32'(sq_rst_n), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    stalled = 1'b0;
    k = n_results;
    cycle(1'b0, 16'd0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) cycle(1'b0, 16'd0, 1'b1);
    chk("midrst_no_result", 32'(n_results - k), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
